// File: rtl/ram_load_arbiter.sv
// RAM load arbiter: a streamed loader (address header, word count, payload)
// owns the RAM while the CPU is halted, then hands the RAM bus to the CPU.
module ram_load_arbiter #(
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     LD_VALID,
  input  logic [15:0]              LD_WORD,
  output logic                     LD_READY,
  input  logic                     LOAD_REQ,
  input  logic                     CPU_RAM_EN,
  input  logic                     CPU_RAM_RW,
  input  logic [ADDRESS_WIDTH-1:0] CPU_ADDRESS,
  input  logic [15:0]              CPU_DATA,
  output logic                     HALT,
  output logic                     RAM_EN,
  output logic                     RAM_RW,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
  output logic [15:0]              DATA_BUS,
  output logic                     LOAD_DONE
);

  typedef enum logic [1:0] {ADDR, CNT, DATA, RUN} state_t;

  state_t                     state, state_nxt;
  logic                       accept;
  logic                       run_pass;
  logic [ADDRESS_WIDTH-1:0]   ptr;
  logic [15:0]                cnt;
  logic                       wr_q;     // registered loader write this cycle
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [15:0]                data_q;
  logic                       done_q;

  assign accept = LD_VALID && LD_READY;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ADDR;
    else        state <= state_nxt;
  end

  // Next state and output muxing; the final payload write still owns the
  // bus (and keeps the CPU halted) in the first RUN cycle.
  always_comb begin
    state_nxt   = state;
    LD_READY    = (state != RUN);
    run_pass    = (state == RUN) && !wr_q;
    HALT        = !run_pass;
    RAM_EN      = wr_q;
    RAM_RW      = !wr_q;
    ADDRESS_BUS = addr_q;
    DATA_BUS    = data_q;
    LOAD_DONE   = done_q;
    case (state)
      ADDR: if (accept) state_nxt = CNT;
      CNT:  if (accept) state_nxt = (LD_WORD == 16'h0000) ? RUN : DATA;
      DATA: if (accept && cnt == 16'd1) state_nxt = RUN;
      RUN:  if (LOAD_REQ) state_nxt = ADDR;
      default: state_nxt = ADDR;
    endcase
    if (run_pass) begin
      RAM_EN      = CPU_RAM_EN;
      RAM_RW      = CPU_RAM_RW;
      ADDRESS_BUS = CPU_ADDRESS;
      DATA_BUS    = CPU_DATA;
    end
  end

  // Loader datapath: pointer/counter, one-cycle write register, done pulse
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr    <= '0;
      cnt    <= '0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= (state != RUN) && (state_nxt == RUN);
      case (state)
        ADDR: if (accept) ptr <= ADDRESS_WIDTH'(LD_WORD);
        CNT:  if (accept) cnt <= LD_WORD;
        DATA: if (accept) begin
          wr_q   <= 1'b1;
          addr_q <= ptr;
          data_q <= LD_WORD;
          ptr    <= ptr + ADDRESS_WIDTH'(1);  // wraps naturally
          cnt    <= cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Randomized bench for ram_load_arbiter: streams are scored against a list of
// expected (address, data) writes derived from the header/count/payload rules.
module tb_ram_load_arbiter;
  localparam int AW = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          LD_VALID = 1'b0;
  logic [15:0]   LD_WORD = '0;
  logic          LD_READY;
  logic          LOAD_REQ = 1'b0;
  logic          CPU_RAM_EN = 1'b0;
  logic          CPU_RAM_RW = 1'b1;
  logic [AW-1:0] CPU_ADDRESS = '0;
  logic [15:0]   CPU_DATA = '0;
  logic          HALT, RAM_EN, RAM_RW, LOAD_DONE;
  logic [AW-1:0] ADDRESS_BUS;
  logic [15:0]   DATA_BUS;

  ram_load_arbiter #(.ADDRESS_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET), .LD_VALID(LD_VALID), .LD_WORD(LD_WORD),
    .LD_READY(LD_READY), .LOAD_REQ(LOAD_REQ), .CPU_RAM_EN(CPU_RAM_EN),
    .CPU_RAM_RW(CPU_RAM_RW), .CPU_ADDRESS(CPU_ADDRESS), .CPU_DATA(CPU_DATA),
    .HALT(HALT), .RAM_EN(RAM_EN), .RAM_RW(RAM_RW), .ADDRESS_BUS(ADDRESS_BUS),
    .DATA_BUS(DATA_BUS), .LOAD_DONE(LOAD_DONE)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  logic [31:0] wr_log[$];
  int          wr_cyc[$];
  int          done_cnt = 0;
  int          halt_fall = -1;
  logic        prev_halt = 1'b1;
  logic [15:0] stim[$];

  always @(posedge CLK) cyc++;

  // Observe loader writes (CPU held) and LOAD_DONE pulses mid-cycle
  always @(negedge CLK) begin
    if (RESET) begin
      if (HALT && RAM_EN && !RAM_RW) begin
        wr_log.push_back({ADDRESS_BUS, DATA_BUS});
        wr_cyc.push_back(cyc);
      end
      if (LOAD_DONE) done_cnt++;
      if (prev_halt && !HALT) halt_fall = cyc;
    end
    prev_halt = HALT;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    wr_log.delete();
    wr_cyc.delete();
    done_cnt  = 0;
    halt_fall = -1;
  endtask

  // mode 0: valid held, 1: valid every other cycle, 2: random valid
  task automatic drive_stream(input int mode, input int nwords);
    int k = 0;
    for (int i = 0; i < nwords; i++) begin
      bit acc = 0;
      int tries = 0;
      while (!acc && tries < 64) begin
        logic v, rdy;
        case (mode)
          0:       v = 1'b1;
          1:       v = (k % 2 == 0);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        LD_VALID = v;
        LD_WORD  = v ? stim[i] : 16'($urandom);
        LOAD_REQ = ($urandom_range(0, 3) == 0);
        rdy = LD_READY;
        @(posedge CLK); #1;
        acc = v && rdy;
        k++;
        tries++;
      end
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    end
    LD_VALID = 1'b0;
    LOAD_REQ = 1'b0;
  endtask

  task automatic check_stream(input string nm, input int mode);
    int n;
    logic [15:0] a;
    repeat (3) @(posedge CLK);
    #1;
    n = int'(stim[1]);
    chk({nm, "_nwr"}, 64'(wr_log.size()), 64'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      a = stim[0] + 16'(i);
      chk({nm, "_wr"}, 64'(wr_log[i]), 64'({a, stim[2+i]}));
    end
    chk({nm, "_done"}, 64'(done_cnt), 64'd1);
    chk({nm, "_halt"}, 64'(HALT), 64'd0);
    chk({nm, "_rdy"}, 64'(LD_READY), 64'd0);
    if (n > 0 && wr_cyc.size() > 0)
      chk({nm, "_haltfall"}, 64'(halt_fall), 64'(wr_cyc[wr_cyc.size()-1] + 1));
    if (mode == 0 && n > 1 && wr_cyc.size() == n)
      chk({nm, "_b2b"}, 64'(wr_cyc[n-1] - wr_cyc[0]), 64'(n - 1));
  endtask

  task automatic reenter_load();
    CPU_RAM_EN = 1'b1;
    LOAD_REQ   = 1'b1;
    @(posedge CLK); #1;
    LOAD_REQ = 1'b0;
    chk("reload_halt", 64'(HALT), 64'd1);
    chk("reload_en", 64'(RAM_EN), 64'd0);
    chk("reload_rdy", 64'(LD_READY), 64'd1);
    CPU_RAM_EN = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_halt", 64'(HALT), 64'd1);
    chk("rst_en", 64'(RAM_EN), 64'd0);
    chk("rst_rw", 64'(RAM_RW), 64'd1);
    chk("rst_addr", 64'(ADDRESS_BUS), 64'd0);
    chk("rst_data", 64'(DATA_BUS), 64'd0);
    chk("rst_done", 64'(LOAD_DONE), 64'd0);
    #20;
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1;
    chk("rel_rdy", 64'(LD_READY), 64'd1);
    chk("rel_halt", 64'(HALT), 64'd1);

    // basic stream, valid held
    stim = '{16'h0010, 16'h0003, 16'h0005, 16'h0000, 16'h0001};
    clear_obs();
    drive_stream(0, stim.size());
    check_stream("basic", 0);

    // CPU pass-through in RUN, then reload
    CPU_RAM_EN = 1'b1; CPU_ADDRESS = 16'h0006; CPU_RAM_RW = 1'b1; CPU_DATA = 16'h1234;
    #1;
    chk("pass_en", 64'(RAM_EN), 64'd1);
    chk("pass_rw", 64'(RAM_RW), 64'd1);
    chk("pass_addr", 64'(ADDRESS_BUS), 64'h6);
    chk("pass_data", 64'(DATA_BUS), 64'h1234);
    CPU_RAM_RW = 1'b0; CPU_DATA = 16'hBEEF; CPU_ADDRESS = 16'h7777;
    #1;
    chk("pass_rw0", 64'(RAM_RW), 64'd0);
    chk("pass_data2", 64'(DATA_BUS), 64'hBEEF);
    chk("pass_addr2", 64'(ADDRESS_BUS), 64'h7777);
    CPU_RAM_RW = 1'b1;
    reenter_load();

    // zero-count stream
    stim = '{16'h0000, 16'h0000};
    clear_obs();
    drive_stream(2, stim.size());
    check_stream("zero", 2);
    reenter_load();

    // address wrap
    stim = '{16'hFFFF, 16'h0002, 16'hAAAA, 16'h5555};
    clear_obs();
    drive_stream(2, stim.size());
    check_stream("wrap", 2);
    reenter_load();

    // toggled valid
    stim = '{16'h0100, 16'h0004, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    clear_obs();
    drive_stream(1, stim.size());
    check_stream("toggle", 1);

    // random streams
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 6);
      int mode = $urandom_range(0, 2);
      reenter_load();
      stim.delete();
      stim.push_back(($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFFF - 16'($urandom_range(0, 3)));
      stim.push_back(16'(n));
      for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
      clear_obs();
      drive_stream(mode, stim.size());
      check_stream("rand", mode);
    end

    // reset mid-load after the second payload word
    reenter_load();
    stim = '{16'h0200, 16'h0004, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    clear_obs();
    drive_stream(0, 4);
    @(negedge CLK); #1;
    RESET = 1'b0;
    #1;
    chk("abort_halt", 64'(HALT), 64'd1);
    chk("abort_en", 64'(RAM_EN), 64'd0);
    chk("abort_rw", 64'(RAM_RW), 64'd1);
    chk("abort_addr", 64'(ADDRESS_BUS), 64'd0);
    chk("abort_data", 64'(DATA_BUS), 64'd0);
    chk("abort_done", 64'(LOAD_DONE), 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("abort_nwr", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() >= 2) begin
      chk("abort_wr0", 64'(wr_log[0]), 64'h0200_1111);
      chk("abort_wr1", 64'(wr_log[1]), 64'h0201_2222);
    end
    chk("abort_rdy", 64'(LD_READY), 64'd1);
    chk("abort_ndone", 64'(done_cnt), 64'd0);

    // fresh stream after abort
    stim = '{16'h0300, 16'h0002, 16'hC0DE, 16'hF00D};
    clear_obs();
    drive_stream(0, stim.size());
    check_stream("post_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
